state_serializer: RTL

//   Read-side companion to the lab's parallel state registers: accepts a WIDTH-bit word

---
 rtl/lab6_pkg.sv | 15 +
 rtl/state_serializer_shift_reg_core.sv | 41 ++++
 rtl/state_serializer.sv | 85 ++++++++
 3 files changed

// File: rtl/lab6_pkg.sv
// Shared types for the state-register read path: serializer FSM states and
// the bit-counter width helper.
package lab6_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Counter wide enough to index WIDTH bits (0..WIDTH-1).
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/state_serializer_shift_reg_core.sv
// WIDTH-bit parallel-load shift register with zero fill; shift direction is
// chosen by shift_left so the output end is always bit WIDTH-1 or bit 0.
module shift_reg_core
    import lab6_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             shift_left,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift_en) begin
            data_d = shift_left ? {data_q[WIDTH-2:0], 1'b0} : {1'b0, data_q[WIDTH-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignment only; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/state_serializer.sv
// Parallel-to-serial converter: accepts one WIDTH-bit word on a valid/ready
// handshake and streams it bit by bit under ser_ready back-pressure.
module state_serializer
    import lab6_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] par_din,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             ser_dout,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy
);

    localparam int                CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] sreg;
    logic             load;
    logic             xfer;
    logic             in_shift;

    assign in_shift = (state_q == ST_SHIFT);
    assign load     = (state_q == ST_IDLE) && par_valid;
    assign xfer     = in_shift && ser_ready;

    shift_reg_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (par_din),
        .shift_en   (xfer),
        .shift_left (MSB_FIRST),
        .data       (sreg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
        end else if (xfer) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only, so ser_ready/par_* never reach them combinationally.
    assign par_ready = (state_q == ST_IDLE);
    assign busy      = in_shift;
    assign ser_valid = in_shift;
    assign ser_first = in_shift && (cnt_q == '0);
    assign ser_last  = in_shift && (cnt_q == CNT_LAST);
    assign ser_dout  = in_shift ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_LEVEL;

endmodule
